// File: rtl/locl_rxb_pkg.sv
// Shared types and constants for the local NoC receive packet buffer.
package locl_rxb_pkg;

  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned PTYPE_W = 3;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned MGRID_W = 6;
  localparam int unsigned CNT_W   = 16;

  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_PKT  = 2'd1,
    ST_DISCARD = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [1:0]         cntl;
    logic [TYPE_W-1:0]  pkt_type;
    logic [PTYPE_W-1:0] ptype;
    logic               pvalid;
    logic [MGRID_W-1:0] mgr_id;
    logic [DATA_W-1:0]  data;
  } flit_t;

endpackage

// File: rtl/locl_rxb_mem.sv
// Flit storage: DEPTH x flit_t register array, one write port, registered read
// with write-to-read forwarding so a flit written this cycle can be shown next cycle.
module locl_rxb_mem
  import locl_rxb_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  flit_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output flit_t         rdata_o
);

  flit_t mem_q [DEPTH];
  flit_t rdata_q;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; clears to zero on reset so idle output fields read 0.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/noc_locl_rx_pkt_buffer.sv
// Store-and-forward buffer on the local NoC receive path: only complete,
// well-formed packets are presented downstream. Optional manager-ID filter
// is enabled with `define LOCL_RXB_MGRID_FILTER_EN.
module noc_locl_rx_pkt_buffer
  import locl_rxb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset_poweron,
  input  logic               noc__locl__dp_valid,
  input  logic [1:0]         noc__locl__dp_cntl,
  output logic               locl__noc__dp_ready,
  input  logic [TYPE_W-1:0]  noc__locl__dp_type,
  input  logic [PTYPE_W-1:0] noc__locl__dp_ptype,
  input  logic [DATA_W-1:0]  noc__locl__dp_data,
  input  logic               noc__locl__dp_pvalid,
  input  logic [MGRID_W-1:0] noc__locl__dp_mgrId,
  output logic               rxb__cons__dp_valid,
  output logic [1:0]         rxb__cons__dp_cntl,
  input  logic               cons__rxb__dp_ready,
  output logic [TYPE_W-1:0]  rxb__cons__dp_type,
  output logic [PTYPE_W-1:0] rxb__cons__dp_ptype,
  output logic [DATA_W-1:0]  rxb__cons__dp_data,
  output logic               rxb__cons__dp_pvalid,
  output logic [MGRID_W-1:0] rxb__cons__dp_mgrId,
  output logic [CNT_W-1:0]   rxb__pkt_count,
  output logic               rxb__err_malformed,
  output logic               rxb__err_oversize
`ifdef LOCL_RXB_MGRID_FILTER_EN
  ,
  input  logic [MGRID_W-1:0] cfg__rxb__mgrId,
  output logic [CNT_W-1:0]   rxb__filt_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  wr_state_e       state_q, state_d;
  logic [PW-1:0]   wr_spec_q, wr_spec_d;
  logic [PW-1:0]   wr_commit_q, wr_commit_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   ws_c;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic            mal_q, mal_d;
  logic            ovs_q, ovs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            accept, pop, we, start;
  flit_t           in_flit, out_flit;
`ifdef LOCL_RXB_MGRID_FILTER_EN
  logic [CNT_W-1:0] filt_q, filt_d;
`endif

  assign accept = noc__locl__dp_valid && ready_q;
  assign pop    = valid_q && cons__rxb__dp_ready;

  assign in_flit = '{cntl:     noc__locl__dp_cntl,
                     pkt_type: noc__locl__dp_type,
                     ptype:    noc__locl__dp_ptype,
                     pvalid:   noc__locl__dp_pvalid,
                     mgr_id:   noc__locl__dp_mgrId,
                     data:     noc__locl__dp_data};

  // Write FSM, pointer update, oversize detection and next output values.
  always_comb begin
    state_d     = state_q;
    wr_spec_d   = wr_spec_q;
    wr_commit_d = wr_commit_q;
    cnt_d       = cnt_q;
    mal_d       = 1'b0;
    ovs_d       = 1'b0;
    we          = 1'b0;
    start       = 1'b0;
    ws_c        = wr_spec_q;
`ifdef LOCL_RXB_MGRID_FILTER_EN
    filt_d      = filt_q;
`endif
    rd_d = rd_q + PW'(pop);

    if (accept) begin
      unique case (state_q)
        ST_IDLE: begin
          case (noc__locl__dp_cntl)
            CNTL_SOM, CNTL_SOM_EOM: start = 1'b1;
            CNTL_MOM: begin
              mal_d   = 1'b1;
              state_d = ST_DISCARD;
            end
            default: mal_d = 1'b1;
          endcase
        end
        ST_IN_PKT: begin
          case (noc__locl__dp_cntl)
            CNTL_MOM: begin
              we        = 1'b1;
              wr_spec_d = wr_spec_q + PW'(1);
            end
            CNTL_EOM: begin
              we          = 1'b1;
              wr_spec_d   = wr_spec_q + PW'(1);
              wr_commit_d = wr_spec_q + PW'(1);
              cnt_d       = cnt_q + CNT_W'(1);
              state_d     = ST_IDLE;
            end
            default: begin
              // Restart mid-packet: drop the partial packet, then start afresh.
              ws_c      = wr_commit_q;
              wr_spec_d = wr_commit_q;
              mal_d     = 1'b1;
              start     = 1'b1;
            end
          endcase
        end
        ST_DISCARD: begin
          case (noc__locl__dp_cntl)
            CNTL_SOM: start = 1'b1;
            CNTL_MOM: state_d = ST_DISCARD;
            default:  state_d = ST_IDLE;
          endcase
        end
        default: state_d = ST_IDLE;
      endcase

      if (start) begin
`ifdef LOCL_RXB_MGRID_FILTER_EN
        if (noc__locl__dp_mgrId != cfg__rxb__mgrId) begin
          filt_d  = filt_q + CNT_W'(1);
          state_d = (noc__locl__dp_cntl == CNTL_SOM) ? ST_DISCARD : ST_IDLE;
        end else
`endif
        begin
          we        = 1'b1;
          wr_spec_d = ws_c + PW'(1);
          if (noc__locl__dp_cntl == CNTL_SOM) begin
            state_d = ST_IN_PKT;
          end else begin
            wr_commit_d = ws_c + PW'(1);
            cnt_d       = cnt_q + CNT_W'(1);
            state_d     = ST_IDLE;
          end
        end
      end
    end

    // A full buffer holding only an uncommitted packet can never drain.
    if ((state_d == ST_IN_PKT) && ((wr_spec_d - rd_d) == PW'(DEPTH)) &&
        (wr_commit_d == rd_d)) begin
      wr_spec_d = wr_commit_d;
      state_d   = ST_DISCARD;
      ovs_d     = 1'b1;
    end

    ready_d = (state_d == ST_DISCARD) || ((wr_spec_d - rd_d) != PW'(DEPTH));
    valid_d = (rd_d != wr_commit_d);
  end

  // State, pointer and status registers.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q     <= ST_IDLE;
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
      rd_q        <= '0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      mal_q       <= 1'b0;
      ovs_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_spec_q   <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
      rd_q        <= rd_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      mal_q       <= mal_d;
      ovs_q       <= ovs_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef LOCL_RXB_MGRID_FILTER_EN
  // Filtered-packet counter.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
  assign rxb__filt_count = filt_q;
`endif

  locl_rxb_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_i   (reset_poweron),
    .we_i    (we),
    .waddr_i (ws_c[AW-1:0]),
    .wdata_i (in_flit),
    .raddr_i (rd_d[AW-1:0]),
    .rdata_o (out_flit)
  );

  assign locl__noc__dp_ready  = ready_q;
  assign rxb__cons__dp_valid  = valid_q;
  assign rxb__cons__dp_cntl   = out_flit.cntl;
  assign rxb__cons__dp_type   = out_flit.pkt_type;
  assign rxb__cons__dp_ptype  = out_flit.ptype;
  assign rxb__cons__dp_data   = out_flit.data;
  assign rxb__cons__dp_pvalid = out_flit.pvalid;
  assign rxb__cons__dp_mgrId  = out_flit.mgr_id;
  assign rxb__pkt_count       = cnt_q;
  assign rxb__err_malformed   = mal_q;
  assign rxb__err_oversize    = ovs_q;

endmodule

// File: tb/tb_noc_locl_rx_pkt_buffer.sv
// Bench for noc_locl_rx_pkt_buffer: directed scenarios then random traffic,
// checked every cycle against a packet-level queue model.
module tb_noc_locl_rx_pkt_buffer;
  import locl_rxb_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int M_IDLE = 0;
  localparam int M_IN   = 1;
  localparam int M_DISC = 2;
`ifdef LOCL_RXB_MGRID_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_poweron;
  logic               d_vld;
  logic [1:0]         d_cntl;
  logic [TYPE_W-1:0]  d_type;
  logic [PTYPE_W-1:0] d_ptype;
  logic [DATA_W-1:0]  d_data;
  logic               d_pvalid;
  logic [MGRID_W-1:0] d_mgr;
  logic               cons_rdy;
  logic               ready;
  logic               o_valid;
  logic [1:0]         o_cntl;
  logic [TYPE_W-1:0]  o_type;
  logic [PTYPE_W-1:0] o_ptype;
  logic [DATA_W-1:0]  o_data;
  logic               o_pvalid;
  logic [MGRID_W-1:0] o_mgr;
  logic [CNT_W-1:0]   o_cnt;
  logic               o_mal;
  logic               o_ovs;
  logic [MGRID_W-1:0] cfg_mgr = 6'h2A;
`ifdef LOCL_RXB_MGRID_FILTER_EN
  logic [CNT_W-1:0]   o_filt;
`endif

  noc_locl_rx_pkt_buffer #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset_poweron        (reset_poweron),
    .noc__locl__dp_valid  (d_vld),
    .noc__locl__dp_cntl   (d_cntl),
    .locl__noc__dp_ready  (ready),
    .noc__locl__dp_type   (d_type),
    .noc__locl__dp_ptype  (d_ptype),
    .noc__locl__dp_data   (d_data),
    .noc__locl__dp_pvalid (d_pvalid),
    .noc__locl__dp_mgrId  (d_mgr),
    .rxb__cons__dp_valid  (o_valid),
    .rxb__cons__dp_cntl   (o_cntl),
    .cons__rxb__dp_ready  (cons_rdy),
    .rxb__cons__dp_type   (o_type),
    .rxb__cons__dp_ptype  (o_ptype),
    .rxb__cons__dp_data   (o_data),
    .rxb__cons__dp_pvalid (o_pvalid),
    .rxb__cons__dp_mgrId  (o_mgr),
    .rxb__pkt_count       (o_cnt),
    .rxb__err_malformed   (o_mal),
    .rxb__err_oversize    (o_ovs)
`ifdef LOCL_RXB_MGRID_FILTER_EN
    ,
    .cfg__rxb__mgrId      (cfg_mgr),
    .rxb__filt_count      (o_filt)
`endif
  );

  // Reference model: committed packets queue, packet under assembly, mode.
  flit_t            cq[$];
  flit_t            cur[$];
  int               mode;
  bit               m_ready;
  bit               m_rst;
  bit               e_mal, e_ovs;
  logic [CNT_W-1:0] m_cnt;
  logic [CNT_W-1:0] m_filt;
  bit               rand_mgr;
  int               n_vec, n_err;

  function automatic flit_t drv_flit();
    flit_t f;
    f.cntl = d_cntl; f.pkt_type = d_type; f.ptype = d_ptype;
    f.pvalid = d_pvalid; f.mgr_id = d_mgr; f.data = d_data;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_start(input flit_t f);
    if (FILT && (f.mgr_id != cfg_mgr)) begin
      m_filt++;
      mode = (f.cntl == CNTL_SOM) ? M_DISC : M_IDLE;
    end else if (f.cntl == CNTL_SOM) begin
      cur.delete();
      cur.push_back(f);
      mode = M_IN;
    end else begin
      cq.push_back(f);
      m_cnt++;
      mode = M_IDLE;
    end
  endtask

  task automatic model_edge();
    flit_t f;
    bit acc, pop;
    f   = drv_flit();
    acc = d_vld && m_ready;
    pop = (cq.size() != 0) && cons_rdy;
    e_mal = 1'b0;
    e_ovs = 1'b0;
    if (reset_poweron) begin
      cq.delete(); cur.delete();
      mode = M_IDLE; m_cnt = '0; m_filt = '0; m_ready = 1'b0; m_rst = 1'b1;
      return;
    end
    m_rst = 1'b0;
    if (pop) void'(cq.pop_front());
    if (acc) begin
      case (mode)
        M_IDLE: begin
          if (f.cntl == CNTL_SOM || f.cntl == CNTL_SOM_EOM) model_start(f);
          else if (f.cntl == CNTL_MOM) begin e_mal = 1'b1; mode = M_DISC; end
          else e_mal = 1'b1;
        end
        M_IN: begin
          if (f.cntl == CNTL_MOM) cur.push_back(f);
          else if (f.cntl == CNTL_EOM) begin
            cur.push_back(f);
            foreach (cur[i]) cq.push_back(cur[i]);
            cur.delete();
            m_cnt++;
            mode = M_IDLE;
          end else begin
            cur.delete();
            e_mal = 1'b1;
            model_start(f);
          end
        end
        default: begin
          if (f.cntl == CNTL_SOM) model_start(f);
          else if (f.cntl != CNTL_MOM) mode = M_IDLE;
        end
      endcase
    end
    if (mode == M_IN && (cq.size() + cur.size() == DEPTH) && cq.size() == 0) begin
      cur.delete();
      mode  = M_DISC;
      e_ovs = 1'b1;
    end
    m_ready = (mode == M_DISC) || (cq.size() + cur.size() < DEPTH);
  endtask

  task automatic check_outputs();
    chk("ready", 64'(ready), 64'(m_ready));
    chk("valid", 64'(o_valid), 64'(cq.size() != 0));
    chk("pkt_count", 64'(o_cnt), 64'(m_cnt));
    chk("err_malformed", 64'(o_mal), 64'(e_mal));
    chk("err_oversize", 64'(o_ovs), 64'(e_ovs));
`ifdef LOCL_RXB_MGRID_FILTER_EN
    chk("filt_count", 64'(o_filt), 64'(m_filt));
`endif
    if (m_rst) begin
      chk("rst_data", o_data, 64'd0);
      chk("rst_cntl", 64'(o_cntl), 64'd0);
    end else if (cq.size() != 0) begin
      chk("data", o_data, cq[0].data);
      chk("cntl", 64'(o_cntl), 64'(cq[0].cntl));
      chk("type", 64'(o_type), 64'(cq[0].pkt_type));
      chk("ptype", 64'(o_ptype), 64'(cq[0].ptype));
      chk("pvalid", 64'(o_pvalid), 64'(cq[0].pvalid));
      chk("mgrId", 64'(o_mgr), 64'(cq[0].mgr_id));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_flit(input logic [1:0] c, input logic [63:0] d);
    d_cntl   = c;
    d_data   = d;
    d_type   = TYPE_W'($urandom);
    d_ptype  = PTYPE_W'($urandom);
    d_pvalid = 1'($urandom);
    if (FILT && !rand_mgr) d_mgr = cfg_mgr;
    else if (FILT) d_mgr = ($urandom_range(0, 7) == 0) ? MGRID_W'($urandom) : cfg_mgr;
    else d_mgr = MGRID_W'($urandom);
  endtask

  task automatic send(input logic [1:0] c, input logic [63:0] d);
    bit acc;
    acc = 1'b0;
    set_flit(c, d);
    d_vld = 1'b1;
    for (int i = 0; i < 64; i++) begin
      acc = m_ready;
      step();
      if (acc) break;
    end
    chk("send_accepted", 64'(acc), 64'd1);
    d_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    d_vld = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_poweron = 1'b1;
    d_vld = 1'b0;
    step(); step();
    reset_poweron = 1'b0;
    step();
  endtask

  initial begin
    bit acc_prev;
    int r;
    n_vec = 0; n_err = 0;
    mode = M_IDLE; m_ready = 1'b0; m_rst = 1'b1; m_cnt = '0; m_filt = '0;
    e_mal = 1'b0; e_ovs = 1'b0; rand_mgr = 1'b0;
    reset_poweron = 1'b1; d_vld = 1'b0; cons_rdy = 1'b0;
    set_flit(CNTL_MOM, 64'd0);
    @(negedge clk);

    // Reset, then ready rises the cycle after release.
    do_reset();
    chk("post_reset_ready", 64'(ready), 64'd1);
    chk("post_reset_valid", 64'(o_valid), 64'd0);

    // Single SOM_EOM flit shown one cycle after acceptance.
    send(CNTL_SOM_EOM, 64'hA5);
    chk("t1_valid", 64'(o_valid), 64'd1);
    chk("t1_data", o_data, 64'hA5);
    chk("t1_count", 64'(o_cnt), 64'd1);
    cons_rdy = 1'b1;
    idle(2);

    // 4-flit packet held back until EOM, then drains back-to-back.
    cons_rdy = 1'b0;
    send(CNTL_SOM, 64'h100);
    send(CNTL_MOM, 64'h101);
    send(CNTL_MOM, 64'h102);
    chk("t2_hold_valid", 64'(o_valid), 64'd0);
    send(CNTL_EOM, 64'h103);
    chk("t2_eom_valid", 64'(o_valid), 64'd1);
    chk("t2_first", o_data, 64'h100);
    cons_rdy = 1'b1;
    idle(3);
    chk("t2_last", o_data, 64'h103);
    idle(1);
    chk("t2_empty", 64'(o_valid), 64'd0);

    // Framing errors then a good packet.
    send(CNTL_MOM, 64'h200);
    chk("t3_mal_pulse", 64'(o_mal), 64'd1);
    send(CNTL_MOM, 64'h201);
    chk("t3_mal_once", 64'(o_mal), 64'd0);
    send(CNTL_EOM, 64'h202);
    chk("t3_count", 64'(o_cnt), 64'd2);
    send(CNTL_SOM, 64'h210);
    send(CNTL_EOM, 64'h211);
    idle(3);

    // Mid-packet restart.
    send(CNTL_SOM, 64'h300);
    send(CNTL_MOM, 64'h301);
    send(CNTL_SOM, 64'h310);
    chk("t4_mal", 64'(o_mal), 64'd1);
    send(CNTL_EOM, 64'h311);
    chk("t4_count", 64'(o_cnt), 64'd4);
    chk("t4_data", o_data, 64'h310);
    idle(3);

    // Oversize packet of 20 flits, then a 3-flit packet.
    do_reset();
    cons_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send((i == 0) ? CNTL_SOM : (i == 19) ? CNTL_EOM : CNTL_MOM, 64'(16'h400 + i));
      if (i == 15) chk("t5_oversize", 64'(o_ovs), 64'd1);
      if (i >= 15) chk("t5_ready", 64'(ready), 64'd1);
    end
    send(CNTL_SOM, 64'h500);
    send(CNTL_MOM, 64'h501);
    send(CNTL_EOM, 64'h502);
    chk("t5_count", 64'(o_cnt), 64'd1);
    cons_rdy = 1'b1;
    idle(4);

    // Fill with 16 committed flits, pop one, then reset mid-stream.
    do_reset();
    cons_rdy = 1'b0;
    for (int p = 0; p < 4; p++) begin
      send(CNTL_SOM, 64'(16'h600 + 4 * p));
      send(CNTL_MOM, 64'(16'h601 + 4 * p));
      send(CNTL_MOM, 64'(16'h602 + 4 * p));
      send(CNTL_EOM, 64'(16'h603 + 4 * p));
    end
    chk("t6_full_ready", 64'(ready), 64'd0);
    cons_rdy = 1'b1;
    idle(1);
    chk("t6_pop_ready", 64'(ready), 64'd1);
    cons_rdy = 1'b0;
    send(CNTL_SOM, 64'h700);
    reset_poweron = 1'b1;
    step();
    chk("t6_rst_valid", 64'(o_valid), 64'd0);
    chk("t6_rst_count", 64'(o_cnt), 64'd0);
    reset_poweron = 1'b0;
    step();

    // Random traffic with flits held until accepted.
    rand_mgr = 1'b1;
    acc_prev = 1'b1;
    d_vld = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!d_vld || acc_prev) begin
        d_vld = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 19);
        set_flit((r < 3) ? CNTL_SOM : (r < 5) ? CNTL_SOM_EOM :
                 (r < 16) ? CNTL_MOM : CNTL_EOM, {$urandom, $urandom});
      end
      cons_rdy = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      reset_poweron = (i == 2000 || i == 2001);
      acc_prev = d_vld && m_ready;
      step();
    end
    reset_poweron = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noc_locl_rx_pkt_buffer.md
Name: noc_locl_rx_pkt_buffer

Overview:
- Store-and-forward packet buffer on the manager's local NoC receive path.
- Consumes the noc__locl__dp_* stream leaving the NoC controller's local port and re-presents only complete, well-formed packets to the local consumer (WU fetch / descriptor path).
- Guarantees the consumer never stalls mid-packet because of the NoC, and detects framing errors and oversize packets.

Parameters:
- DEPTH, 16: flit entries in buffer memory; power of 2, minimum 4.
- TYPE_W, 2: packet type width (MGR_NOC_CONT_NOC_PACKET_TYPE).
- PTYPE_W, 3: payload type width.
- DATA_W, 64: internal data width (MGR_NOC_CONT_INTERNAL_DATA).
- MGRID_W, 6: manager ID width.
- CNT_W, 16: packet counter width.

Ports:
- clk  in  1  system clock
- reset_poweron  in  1  synchronous, active-high reset
- noc__locl__dp_valid  in  1  upstream flit valid
- noc__locl__dp_cntl  in  2  SOM/MOM/EOM/SOM_EOM
- locl__noc__dp_ready  out  1  buffer accepts flit
- noc__locl__dp_type  in  TYPE_W  packet type (meaningful on SOM)
- noc__locl__dp_ptype  in  PTYPE_W  payload type
- noc__locl__dp_data  in  DATA_W  payload
- noc__locl__dp_pvalid  in  1  payload valid
- noc__locl__dp_mgrId  in  MGRID_W  source manager (meaningful on SOM)
- rxb__cons__dp_valid  out  1  downstream flit valid
- rxb__cons__dp_cntl  out  2  framing
- cons__rxb__dp_ready  in  1  downstream ready
- rxb__cons__dp_type / _ptype / _data / _pvalid / _mgrId  out  as input widths  stored flit fields
- rxb__pkt_count  out  CNT_W  packets committed since reset, wraps
- rxb__err_malformed  out  1  one-cycle pulse, framing error
- rxb__err_oversize  out  1  one-cycle pulse, packet exceeded DEPTH

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high on reset_poweron.
- Cntl encoding (package): MOM=2'b00, SOM=2'b01, EOM=2'b10, SOM_EOM=2'b11.
- Handshake:
  - A transfer occurs when valid and ready are both high in a cycle.
  - Valid is never dropped by the buffer once raised until the transfer completes.
  - Output fields are stable while valid is high and ready is low.
- Pointers:
  - wr_spec: speculative write pointer.
  - wr_commit: packet-committed pointer.
  - rd: read pointer.
  - All are log2(DEPTH)+1 bits; the MSB marks wrap.
  - full = (wr_spec - rd) == DEPTH.
- locl__noc__dp_ready:
  - Equals !full in IDLE and IN_PKT.
  - Forced to 1 in DISCARD.
- Write FSM:
  - IDLE:
    - SOM: write flit, go IN_PKT.
    - SOM_EOM: write flit and commit (wr_commit <= wr_spec+1), stay IDLE.
    - MOM: drop flit, pulse err_malformed, go DISCARD.
    - EOM: drop flit, pulse err_malformed, stay IDLE.
  - IN_PKT:
    - MOM: write flit.
    - EOM: write flit, commit, go IDLE.
    - SOM or SOM_EOM: rewind wr_spec to wr_commit, pulse err_malformed, then treat the flit as if received in IDLE in the same cycle.
  - DISCARD:
    - Drop all flits until EOM or SOM_EOM is accepted, then go IDLE.
    - A SOM seen in DISCARD starts a new packet, as in IDLE.
- Oversize rule:
  - Condition: in IN_PKT, full and wr_commit == rd (no committed flits, so the buffer can never drain).
  - Action: rewind wr_spec to wr_commit, pulse err_oversize, go DISCARD.
- Read side:
  - rxb__cons__dp_valid = (rd != wr_commit).
  - Show-ahead output with a registered storage read.
  - An EOM accepted at cycle N is visible to the consumer no earlier than N+1.
  - Back-to-back flits at 1 per cycle.
- Simultaneous events:
  - Simultaneous read and write on a full buffer: the write is not accepted, because ready was computed on the pre-read full.
  - A rewind never touches rd or committed flits.
- Packet counter:
  - rxb__pkt_count increments by 1 per commit.
  - Wraps at 2^CNT_W.
- Reset:
  - All pointers 0, FSM IDLE.
  - Outputs: valid 0, ready 1 in the cycle after reset deasserts (0 during reset), count 0, error pulses 0, data fields 0.
  - Reset mid-packet discards all contents, including committed but unread flits.

Optional Feature:
- Macro: LOCL_RXB_MGRID_FILTER_EN.
- Defined:
  - Adds input cfg__rxb__mgrId (MGRID_W).
  - A SOM/SOM_EOM whose noc__locl__dp_mgrId differs from cfg__rxb__mgrId sends the FSM to DISCARD (or drops the single SOM_EOM flit).
  - Adds output rxb__filt_count (CNT_W), which increments per filtered packet.
  - No error pulse on a filtered packet.
- Undefined: no filtering, no extra ports.

Decomposition:
- Package locl_rxb_pkg holds:
  - cntl encoding constants;
  - FSM state enum (IDLE, IN_PKT, DISCARD);
  - the packed flit struct {cntl, type, ptype, pvalid, mgrId, data}.
- One sub-module, locl_rxb_mem: simple dual-port DEPTH x flit_t register array with one write port and a registered read.

Test Plan:
- Single SOM_EOM flit, data 0xA5:
  - Consumer sees valid with data 0xA5 one cycle after acceptance.
  - count 0->1.
- Packet of 4 flits (SOM, MOM, MOM, EOM) with cons ready held 0 until EOM:
  - Consumer valid stays 0 until the cycle after EOM.
  - 4 flits then drain back-to-back.
- Framing errors:
  - MOM in IDLE, then MOM, EOM: err_malformed pulses once, nothing is committed, count unchanged.
  - Then a good 2-flit packet is delivered intact.
- Mid-packet restart:
  - SOM, MOM, SOM, EOM: err_malformed pulses once.
  - Only the second 2-flit packet is delivered.
- Oversize, DEPTH=16:
  - A 20-flit packet into an empty buffer gives err_oversize after flit 16, ready held 1, flits 17-20 dropped.
  - A following 3-flit packet is delivered and count=1.
- Full buffer and reset:
  - Fill with 16 committed flits with consumer ready 0: locl__noc__dp_ready goes 0.
  - Pop one flit: ready returns 1 on the next cycle.
  - Assert reset_poweron mid-stream: valid 0 and count 0 the next cycle.
